axis_slave: RTL and testbench
=============================

# axis_slave

AXI4-Stream slave receive stage. It sits downstream of the AXI-Stream master stage on the same 32-bit link and buffers incoming beats in a first-word-fall-through FIFO. It presents each beat to a backend consumer over a valid/ready interface, and reports packet completion and backend stall.

## Interface
Parameters:
- FIFO_DEPTH, 8, FIFO entries; power of two, 2..64.
- RDY_TIMEOUT, 5, consecutive backend-stall cycles before bk_nordy asserts; 1..255.

Ports:
- axi_aclk  in  1  clock; all logic on rising edge.
- axi_reset  in  1  synchronous, active-high reset.
- axis_tvalid  in  1  beat valid.
- axis_tdata  in  32  beat data.
- axis_tstrb  in  4  byte strobes.
- axis_tkeep  in  4  byte keeps.
- axis_tlast  in  1  last beat of packet.
- axis_tuser  in  2  sideband.
- axis_tready  out  1  slave can accept a beat.
- bk_valid  out  1  head beat available to backend.
- bk_data  out  32  head beat data.
- bk_tstrb  out  4  head beat strobes.
- bk_tkeep  out  4  head beat keeps.
- bk_user  out  2  head beat sideband.
- bk_tlast  out  1  head beat is last of its packet.
- bk_ready  in  1  backend takes head beat.
- bk_nordy  out  1  backend stalled ≥ RDY_TIMEOUT cycles.
- bk_done  out  1  one-cycle pulse: a tlast beat was consumed.
- pkt_active  out  1  mid-packet; first beat accepted, tlast not yet accepted.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- pkt_count  out  16  consumed-packet count (see Configuration).

## Operation
- FIFO entry is 43 bits: {tdata, tstrb, tkeep, tuser, tlast}.
- Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The level counter is one bit wider.
- axis_tready = !full & !axi_reset. It depends only on the registered level and never on axis_tvalid.
- Accept occurs when axis_tvalid & axis_tready.
- Null beat (axis_tkeep == 4'h0):
  - It is accepted but not stored.
  - Its tlast still drives the FSM.
  - The stored copy of the previous beat's tlast is not modified.
- Push occurs on accept with axis_tkeep != 0.
- Pop occurs when bk_valid & bk_ready.
- bk_valid = !empty. The bk_* data fields always show the head entry, and read as 0 when the FIFO is empty.
- A push and a pop in the same cycle leave the level unchanged. At full, tready is low, so no push can occur.
- FSM on accepted beats, states S_IDLE and S_PKT:
  - S_IDLE → S_PKT: accept with tlast = 0.
  - S_IDLE: accept with tlast = 1 (single-beat packet) stays in S_IDLE.
  - S_PKT → S_IDLE: accept with tlast = 1.
  - pkt_active = (state == S_PKT).
- Stall counter:
  - 8 bits, saturates at 255.
  - Increments when bk_valid & !bk_ready.
  - Clears on pop or when bk_valid is low.
  - bk_nordy = (stall count ≥ RDY_TIMEOUT).
- bk_done is registered. It is high the cycle after a pop whose bk_tlast = 1.
- Backend protocol: once bk_valid is high it stays high, with the head beat stable, until a pop.

## Timing
- Reset, applied on any edge where axi_reset = 1:
  - Pointers, level, FSM, stall counter, bk_done and pkt_count return to 0 / S_IDLE.
  - Buffered beats are discarded.
- Values during reset: axis_tready = 0, bk_valid = 0, bk_nordy = 0, bk_done = 0, pkt_active = 0, fifo_level = 0, pkt_count = 0.
- First cycle after reset release: axis_tready = 1.
- Ingress-to-egress latency:
  - A beat accepted at edge N appears on bk_valid/bk_* in the cycle after edge N.
  - It can be popped at edge N+1.
- Throughput: one beat per cycle sustained when bk_ready = 1.
- Full boundary: the level reaches FIFO_DEPTH, and axis_tready drops the following cycle. It rises one cycle after the first pop.
- Empty boundary: bk_valid drops in the cycle after the pop of the last entry, unless a push happens at the same edge.
- Reset mid-packet: the partial packet is dropped and no bk_done is issued.

## Configuration
- Macro AXIS_SLAVE_PKT_CNT_EN, when defined:
  - pkt_count is a 16-bit register.
  - It increments on each pop with bk_tlast = 1.
  - It wraps 16'hFFFF → 16'h0000.
- Macro AXIS_SLAVE_PKT_CNT_EN, when undefined:
  - The counter logic is absent.
  - The pkt_count port remains and is tied to 16'h0000.

## Test plan
- Single-beat packet:
  - Stimulus: tdata = 32'hA5A5_0001, tkeep = 4'hF, tlast = 1, bk_ready = 1.
  - Response: bk_valid goes high the cycle after accept, bk_tlast = 1, bk_done pulses one cycle after the pop, pkt_active stays 0, and pkt_count = 1 (macro defined).
- Fill to full:
  - Stimulus: bk_ready = 0; 9 beats tdata = 0..8, tvalid held high.
  - Response: 8 accepted, fifo_level = 8, axis_tready = 0; after ≥ 5 stall cycles bk_nordy = 1; when bk_ready goes high, data pops in order 0..7, then beat 8 is accepted.
- Streaming:
  - Stimulus: 16-beat packet, tvalid and bk_ready constantly high.
  - Response: one beat per cycle, fifo_level ≤ 1, pkt_active high from beat 0 to beat 14, a single bk_done.
- Null beat:
  - Stimulus: beat 1 of 3 has tkeep = 4'h0; beat 2 has tlast = 1.
  - Response: the backend sees only beats 0 and 2, and bk_done pulses once.
- Reset mid-packet:
  - Stimulus: 3 beats of an unterminated packet buffered, then axi_reset = 1 for 1 cycle.
  - Response: fifo_level = 0, bk_valid = 0, pkt_active = 0, no bk_done; the next packet is received intact.
- Counter wrap (macro defined):
  - Stimulus: force pkt_count to 16'hFFFF, then send 1 packet.
  - Response: pkt_count = 16'h0000.

Source files
------------

// File: rtl/axis_slave.sv
// axis_slave: AXI4-Stream slave receive stage.
// Buffers incoming 32-bit beats in a first-word-fall-through FIFO and presents
// the head beat to a backend consumer over valid/ready. Reports packet
// completion (bk_done), backend stall (bk_nordy) and mid-packet state.
// Optional feature: define AXIS_SLAVE_PKT_CNT_EN to enable the consumed-packet
// counter on pkt_count; otherwise pkt_count is tied to zero.
module axis_slave #(
    parameter int FIFO_DEPTH  = 8,
    parameter int RDY_TIMEOUT = 5
) (
    input  logic                          axi_aclk,
    input  logic                          axi_reset,
    input  logic                          axis_tvalid,
    input  logic [31:0]                   axis_tdata,
    input  logic [3:0]                    axis_tstrb,
    input  logic [3:0]                    axis_tkeep,
    input  logic                          axis_tlast,
    input  logic [1:0]                    axis_tuser,
    output logic                          axis_tready,
    output logic                          bk_valid,
    output logic [31:0]                   bk_data,
    output logic [3:0]                    bk_tstrb,
    output logic [3:0]                    bk_tkeep,
    output logic [1:0]                    bk_user,
    output logic                          bk_tlast,
    input  logic                          bk_ready,
    output logic                          bk_nordy,
    output logic                          bk_done,
    output logic                          pkt_active,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   pkt_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L   = FIFO_DEPTH[AW:0];
    localparam logic [7:0]  TIMEOUT_L = RDY_TIMEOUT[7:0];

    typedef enum logic {S_IDLE, S_PKT} state_t;

    // 43-bit FIFO entry, field order {tdata, tstrb, tkeep, tuser, tlast}
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic [1:0]  user;
        logic        last;
    } entry_t;

    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [7:0]    stall_cnt;
    state_t        state;
    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;

    assign full        = (level == DEPTH_L);
    assign empty       = (level == '0);
    assign axis_tready = !full && !axi_reset;
    assign accept      = axis_tvalid && axis_tready;
    // Null beats (no bytes kept) are accepted for framing but never stored.
    assign push        = accept && (axis_tkeep != 4'h0);
    assign bk_valid    = !empty;
    assign pop         = bk_valid && bk_ready;

    // Storage write; entries are only ever read when the level says they are valid.
    // NOTE: the storage array has no reset -- stale contents are unreachable
    // because bk_* are masked while empty, and resetting it would cost a mux per bit.
    always_ff @(posedge axi_aclk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: axis_tdata, strb: axis_tstrb, keep: axis_tkeep,
                             user: axis_tuser, last: axis_tlast};
        end
    end

    // Head-of-FIFO presentation; reads as zero while the FIFO is empty.
    always_comb begin
        // NOTE: default assignment first so every path drives head and no latch is inferred.
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr];
        end
    end

    assign bk_data  = head.data;
    assign bk_tstrb = head.strb;
    assign bk_tkeep = head.keep;
    assign bk_user  = head.user;
    assign bk_tlast = head.last;

    // Pointer and occupancy tracking; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge axi_aclk) begin
        // NOTE: non-blocking assignments for all sequential state so every
        // register samples pre-edge values regardless of block ordering.
        if (axi_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign fifo_level = level;

    // Packet framing FSM driven by every accepted beat, including null beats.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state <= S_IDLE;
        end else if (accept) begin
            state <= axis_tlast ? S_IDLE : S_PKT;
        end
    end

    assign pkt_active = (state == S_PKT);

    // Backend stall counter: counts consecutive cycles a head beat waits, saturating.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            stall_cnt <= '0;
        end else if (pop || !bk_valid) begin
            stall_cnt <= '0;
        end else if (stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bk_nordy = (stall_cnt >= TIMEOUT_L);

    // Completion pulse the cycle after the last beat of a packet is consumed.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            bk_done <= 1'b0;
        end else begin
            bk_done <= pop && head.last;
        end
    end

`ifdef AXIS_SLAVE_PKT_CNT_EN
    logic [15:0] pkt_cnt;

    // Consumed-packet counter; wraps from 16'hFFFF to zero.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            pkt_cnt <= '0;
        end else if (pop && head.last) begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end
    end

    assign pkt_count = pkt_cnt;
`else
    assign pkt_count = 16'h0000;
`endif

endmodule

// File: tb/tb_axis_slave.sv
// tb_axis_slave: self-checking bench for axis_slave.
// A queue-based model tracks what the FIFO must hold and what every output must
// read; a compare process checks it each cycle, and directed scenarios pin the
// model with hand-computed literal expectations.
module tb_axis_slave;

    localparam int DEPTH = 8;
    localparam int TMO   = 5;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic [1:0]  user;
        logic        last;
    } beat_t;

    logic        axi_aclk = 1'b0;
    logic        axi_reset;
    logic        axis_tvalid;
    logic [31:0] axis_tdata;
    logic [3:0]  axis_tstrb;
    logic [3:0]  axis_tkeep;
    logic        axis_tlast;
    logic [1:0]  axis_tuser;
    logic        axis_tready;
    logic        bk_valid;
    logic [31:0] bk_data;
    logic [3:0]  bk_tstrb;
    logic [3:0]  bk_tkeep;
    logic [1:0]  bk_user;
    logic        bk_tlast;
    logic        bk_ready;
    logic        bk_nordy;
    logic        bk_done;
    logic        pkt_active;
    logic [3:0]  fifo_level;
    logic [15:0] pkt_count;

    int n_cmp = 0;
    int n_err = 0;

    axis_slave #(.FIFO_DEPTH(DEPTH), .RDY_TIMEOUT(TMO)) dut (
        .axi_aclk    (axi_aclk),
        .axi_reset   (axi_reset),
        .axis_tvalid (axis_tvalid),
        .axis_tdata  (axis_tdata),
        .axis_tstrb  (axis_tstrb),
        .axis_tkeep  (axis_tkeep),
        .axis_tlast  (axis_tlast),
        .axis_tuser  (axis_tuser),
        .axis_tready (axis_tready),
        .bk_valid    (bk_valid),
        .bk_data     (bk_data),
        .bk_tstrb    (bk_tstrb),
        .bk_tkeep    (bk_tkeep),
        .bk_user     (bk_user),
        .bk_tlast    (bk_tlast),
        .bk_ready    (bk_ready),
        .bk_nordy    (bk_nordy),
        .bk_done     (bk_done),
        .pkt_active  (pkt_active),
        .fifo_level  (fifo_level),
        .pkt_count   (pkt_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    beat_t       q[$];
    logic        m_active = 1'b0;
    logic        m_done   = 1'b0;
    int          m_stall  = 0;
    logic [15:0] m_pkts   = 16'h0;
    logic        m_valid  = 1'b0;
    logic        m_acc;
    logic        m_pop;

    always @(posedge axi_aclk) begin
        if (axi_reset) begin
            q.delete();
            m_active = 1'b0;
            m_done   = 1'b0;
            m_stall  = 0;
            m_pkts   = 16'h0;
        end else begin
            m_acc  = axis_tvalid && (q.size() < DEPTH);
            m_pop  = (q.size() > 0) && bk_ready;
            m_done = m_pop && q[0].last;
            if (q.size() > 0 && !bk_ready) m_stall = (m_stall < 255) ? m_stall + 1 : 255;
            else                           m_stall = 0;
            if (m_pop) begin
`ifdef AXIS_SLAVE_PKT_CNT_EN
                if (q[0].last) m_pkts = m_pkts + 16'h1;
`endif
                void'(q.pop_front());
            end
            if (m_acc) begin
                if (axis_tkeep != 4'h0)
                    q.push_back('{data: axis_tdata, strb: axis_tstrb, keep: axis_tkeep,
                                  user: axis_tuser, last: axis_tlast});
                m_active = !axis_tlast;
            end
        end
        m_valid = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    beat_t exp_head;
    always @(posedge axi_aclk) begin
        #1;
        if (m_valid) begin
            exp_head = (q.size() > 0) ? q[0] : '0;
            check("tready",     64'(axis_tready), 64'(!axi_reset && q.size() < DEPTH));
            check("bk_valid",   64'(bk_valid),    64'(q.size() > 0));
            check("fifo_level", 64'(fifo_level),  64'(q.size()));
            check("bk_data",    64'(bk_data),     64'(exp_head.data));
            check("bk_tstrb",   64'(bk_tstrb),    64'(exp_head.strb));
            check("bk_tkeep",   64'(bk_tkeep),    64'(exp_head.keep));
            check("bk_user",    64'(bk_user),     64'(exp_head.user));
            check("bk_tlast",   64'(bk_tlast),    64'(exp_head.last));
            check("pkt_active", 64'(pkt_active),  64'(m_active));
            check("bk_done",    64'(bk_done),     64'(m_done));
            check("bk_nordy",   64'(bk_nordy),    64'(m_stall >= TMO));
            check("pkt_count",  64'(pkt_count),   64'(m_pkts));
        end
    end

    // ---------------- monitors ----------------
    logic [31:0] popped[$];
    int          done_cnt = 0;

    always @(posedge axi_aclk)
        if (!axi_reset && bk_valid && bk_ready) popped.push_back(bk_data);

    always @(negedge axi_aclk)
        if (bk_done) done_cnt++;

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = 0;
        axis_tvalid = 1'b1;
        axis_tdata  = d;
        axis_tstrb  = d[7:4];
        axis_tkeep  = k;
        axis_tlast  = l;
        axis_tuser  = d[1:0];
        while (!axis_tready && n < 50) begin
            @(negedge axi_aclk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: tready stayed 0 for %0d cycles, required 1 within 50", n);
            axis_tvalid = 1'b0;
        end else begin
            @(posedge axi_aclk);
            @(negedge axi_aclk);
            axis_tvalid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge axi_aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        axi_reset   = 1'b1;
        axis_tvalid = 1'b0;
        axis_tdata  = '0;
        axis_tstrb  = '0;
        axis_tkeep  = '0;
        axis_tlast  = 1'b0;
        axis_tuser  = '0;
        bk_ready    = 1'b0;

        // Reset state
        idle(3);
        check("rst_tready", 64'(axis_tready), 64'd0);
        check("rst_bk_valid", 64'(bk_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        axi_reset = 1'b0;
        idle(1);
        check("post_rst_tready", 64'(axis_tready), 64'd1);

        // Single-beat packet
        bk_ready = 1'b1;
        popped.delete();
        done_cnt = 0;
        send(32'hA5A5_0001, 4'hF, 1'b1);
        check("single_valid", 64'(bk_valid), 64'd1);
        check("single_data", 64'(bk_data), 64'hA5A5_0001);
        check("single_tlast", 64'(bk_tlast), 64'd1);
        check("single_active", 64'(pkt_active), 64'd0);
        idle(1);
        check("single_done", 64'(bk_done), 64'd1);
`ifdef AXIS_SLAVE_PKT_CNT_EN
        check("single_pkt_count", 64'(pkt_count), 64'd1);
`endif
        idle(1);
        check("single_done_clear", 64'(bk_done), 64'd0);
        check("single_done_cnt", 64'(done_cnt), 64'd1);

        // Fill to full
        bk_ready = 1'b0;
        popped.delete();
        for (int i = 0; i < 8; i++) send(32'(i), 4'hF, 1'b0);
        check("full_level", 64'(fifo_level), 64'd8);
        check("full_tready", 64'(axis_tready), 64'd0);
        fork
            send(32'd8, 4'hF, 1'b1);
            begin
                idle(6);
                check("full_nordy", 64'(bk_nordy), 64'd1);
                check("full_level_held", 64'(fifo_level), 64'd8);
                bk_ready = 1'b1;
            end
        join
        idle(12);
        check("fill_pop_count", 64'(popped.size()), 64'd9);
        for (int i = 0; i < popped.size(); i++)
            check("fill_pop_order", 64'(popped[i]), 64'(i));
        check("fill_nordy_clear", 64'(bk_nordy), 64'd0);

        // Streaming 16-beat packet
        popped.delete();
        done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            send(32'h5000_0000 + 32'(i), 4'hF, (i == 15));
            check("stream_level_le1", 64'(fifo_level <= 1), 64'd1);
            check("stream_active", 64'(pkt_active), 64'(i < 15));
        end
        idle(4);
        check("stream_pops", 64'(popped.size()), 64'd16);
        check("stream_done_cnt", 64'(done_cnt), 64'd1);

        // Null beat in the middle of a packet
        popped.delete();
        done_cnt = 0;
        send(32'hC0DE_0000, 4'hF, 1'b0);
        send(32'hC0DE_0001, 4'h0, 1'b0);
        send(32'hC0DE_0002, 4'h3, 1'b1);
        idle(4);
        check("null_pops", 64'(popped.size()), 64'd2);
        if (popped.size() == 2) begin
            check("null_beat0", 64'(popped[0]), 64'hC0DE_0000);
            check("null_beat2", 64'(popped[1]), 64'hC0DE_0002);
        end
        check("null_done_cnt", 64'(done_cnt), 64'd1);

        // Reset mid-packet
        bk_ready = 1'b0;
        popped.delete();
        done_cnt = 0;
        for (int i = 0; i < 3; i++) send(32'hDEAD_0000 + 32'(i), 4'hF, 1'b0);
        check("pre_rst_level", 64'(fifo_level), 64'd3);
        check("pre_rst_active", 64'(pkt_active), 64'd1);
        axi_reset = 1'b1;
        idle(1);
        check("midrst_level", 64'(fifo_level), 64'd0);
        check("midrst_valid", 64'(bk_valid), 64'd0);
        check("midrst_active", 64'(pkt_active), 64'd0);
        check("midrst_tready", 64'(axis_tready), 64'd0);
        axi_reset = 1'b0;
        bk_ready = 1'b1;
        idle(4);
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        check("midrst_no_pop", 64'(popped.size()), 64'd0);
        send(32'hBEEF_0000, 4'hF, 1'b0);
        send(32'hBEEF_0001, 4'hF, 1'b1);
        idle(4);
        check("after_rst_pops", 64'(popped.size()), 64'd2);
        if (popped.size() == 2) begin
            check("after_rst_beat0", 64'(popped[0]), 64'hBEEF_0000);
            check("after_rst_beat1", 64'(popped[1]), 64'hBEEF_0001);
        end
        check("after_rst_done", 64'(done_cnt), 64'd1);

`ifdef AXIS_SLAVE_PKT_CNT_EN
        // Counter wrap
        force dut.pkt_cnt = 16'hFFFF;
        m_pkts = 16'hFFFF;
        idle(1);
        release dut.pkt_cnt;
        check("wrap_preset", 64'(pkt_count), 64'hFFFF);
        send(32'h0000_FFFF, 4'hF, 1'b1);
        idle(3);
        check("wrap_pkt_count", 64'(pkt_count), 64'h0000);
`else
        check("pkt_count_tied", 64'(pkt_count), 64'h0000);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
